// File: rtl/rocc_cmd_issuer.sv
// rocc_cmd_issuer
// Core-side endpoint of the RoCC command/response interface.
//  - Issue side: accepts custom-opcode instructions into an in-order command FIFO.
//  - Command side: drives the head entry toward the accelerator. A command that expects a
//    response (xd) is only sent while a response-buffer slot is reserved for it (credits).
//  - Response side: responses have no back-pressure and land in a small buffer that feeds the
//    integer writeback port.
//  - Scoreboard: rd_pending_o marks destination registers with an outstanding result so the
//    pipeline can stall on RAW/WAW hazards.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   flush_i                       discard queued commands that are not sent this cycle
//   issue_*                       issue handshake and instruction fields
//   cmd_*                         command handshake and fields toward the accelerator
//   resp_valid_i/data_i/rd_i      accelerator response (taken whenever valid)
//   wb_*                          writeback handshake, data and destination register
//   rd_pending_o                  destination scoreboard (bit 0 is always 0)
//   busy_o                        anything queued, in flight or buffered
//   resp_err_o                    sticky response error (dropped response)
//
// Build option
//   ROCC_RESP_CHECK_EN            when defined, responses that arrive with nothing in flight or
//                                 to a non-pending rd are dropped and flagged.
module rocc_cmd_issuer #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned CMD_DEPTH  = 4,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  // issue
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [6:0]      issue_funct7_i,
  input  logic [XLEN-1:0] issue_rs1_i,
  input  logic [XLEN-1:0] issue_rs2_i,
  input  logic [4:0]      issue_rd_i,
  input  logic            issue_xd_i,
  // command
  output logic            cmd_valid_o,
  input  logic            cmd_ready_i,
  output logic [6:0]      cmd_funct7_o,
  output logic [XLEN-1:0] cmd_rs1_o,
  output logic [XLEN-1:0] cmd_rs2_o,
  output logic [4:0]      cmd_rd_o,
  output logic            cmd_xd_o,
  // response
  input  logic            resp_valid_i,
  input  logic [XLEN-1:0] resp_data_i,
  input  logic [4:0]      resp_rd_i,
  // writeback
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      wb_rd_o,
  // status
  output logic [31:0]     rd_pending_o,
  output logic            busy_o,
  output logic            resp_err_o
);

  localparam int unsigned CmdAw  = $clog2(CMD_DEPTH);
  localparam int unsigned RespAw = $clog2(RESP_DEPTH);
  localparam int unsigned CntW   = RespAw + 1;

  localparam logic [CmdAw:0]  CmdPtrOne  = {{CmdAw{1'b0}}, 1'b1};
  localparam logic [RespAw:0] RespPtrOne = {{RespAw{1'b0}}, 1'b1};
  localparam logic [CntW-1:0] CntOne     = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [CntW:0]   RespDepthC = (CntW+1)'(RESP_DEPTH);

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  logic [6:0]      cmd_funct7_q [CMD_DEPTH];
  logic [XLEN-1:0] cmd_rs1_q    [CMD_DEPTH];
  logic [XLEN-1:0] cmd_rs2_q    [CMD_DEPTH];
  logic [4:0]      cmd_rd_q     [CMD_DEPTH];
  logic            cmd_xd_q     [CMD_DEPTH];
  logic [CmdAw:0]  cmd_wptr_q, cmd_wptr_d;
  logic [CmdAw:0]  cmd_rptr_q, cmd_rptr_d;

  logic [XLEN-1:0] resp_data_q [RESP_DEPTH];
  logic [4:0]      resp_rd_q   [RESP_DEPTH];
  logic [RespAw:0] resp_wptr_q, resp_wptr_d;
  logic [RespAw:0] resp_rptr_q, resp_rptr_d;

  logic [CntW-1:0] inflight_q, inflight_d;
  logic [31:0]     rd_pending_q, rd_pending_d;
  logic            resp_err_q, resp_err_d;

  // ---------------------------------------------------------------------------------------------
  // Occupancy and handshakes
  // ---------------------------------------------------------------------------------------------
  logic [CmdAw-1:0]  cmd_head_idx, cmd_tail_idx;
  logic [CmdAw:0]    cmd_count;
  logic              cmd_empty, cmd_full;
  logic [RespAw-1:0] resp_head_idx, resp_tail_idx;
  logic [CntW-1:0]   resp_count;
  logic              resp_empty, resp_full;
  logic [CntW:0]     credit_sum;
  logic              credit_ok;
  logic              issue_hs, cmd_hs, wb_hs;
  logic              resp_legal, resp_take, resp_push, resp_err_set;

  assign cmd_head_idx = cmd_rptr_q[CmdAw-1:0];
  assign cmd_tail_idx = cmd_wptr_q[CmdAw-1:0];
  assign cmd_count    = cmd_wptr_q - cmd_rptr_q;
  assign cmd_empty    = (cmd_wptr_q == cmd_rptr_q);
  assign cmd_full     = (cmd_wptr_q[CmdAw] != cmd_rptr_q[CmdAw]) &&
                        (cmd_wptr_q[CmdAw-1:0] == cmd_rptr_q[CmdAw-1:0]);

  assign resp_head_idx = resp_rptr_q[RespAw-1:0];
  assign resp_tail_idx = resp_wptr_q[RespAw-1:0];
  assign resp_count    = resp_wptr_q - resp_rptr_q;
  assign resp_empty    = (resp_wptr_q == resp_rptr_q);
  assign resp_full     = (resp_wptr_q[RespAw] != resp_rptr_q[RespAw]) &&
                         (resp_wptr_q[RespAw-1:0] == resp_rptr_q[RespAw-1:0]);

  // One spare bit so the sum cannot wrap even if unsolicited responses fill the buffer.
  assign credit_sum = {1'b0, inflight_q} + {1'b0, resp_count};
  assign credit_ok  = (credit_sum < RespDepthC);

  // rst_ni gates ready so nothing is acknowledged while reset is held.
  assign issue_ready_o = rst_ni && !cmd_full && !flush_i &&
                         !(issue_xd_i && rd_pending_q[issue_rd_i]);
  assign issue_hs      = issue_valid_i && issue_ready_o;

  assign cmd_funct7_o = cmd_funct7_q[cmd_head_idx];
  assign cmd_rs1_o    = cmd_rs1_q[cmd_head_idx];
  assign cmd_rs2_o    = cmd_rs2_q[cmd_head_idx];
  assign cmd_rd_o     = cmd_rd_q[cmd_head_idx];
  assign cmd_xd_o     = cmd_xd_q[cmd_head_idx];
  assign cmd_valid_o  = !cmd_empty && (!cmd_xd_o || credit_ok);
  assign cmd_hs       = cmd_valid_o && cmd_ready_i;

  assign wb_valid_o = !resp_empty;
  assign wb_data_o  = resp_data_q[resp_head_idx];
  assign wb_rd_o    = resp_rd_q[resp_head_idx];
  assign wb_hs      = wb_valid_o && wb_ready_i;

  assign rd_pending_o = rd_pending_q;
  assign busy_o       = !cmd_empty || (inflight_q != '0) || !resp_empty;
  assign resp_err_o   = resp_err_q;

  // ---------------------------------------------------------------------------------------------
  // Response acceptance
  // ---------------------------------------------------------------------------------------------
`ifdef ROCC_RESP_CHECK_EN
  assign resp_legal = (inflight_q != '0) && ((resp_rd_i == 5'd0) || rd_pending_q[resp_rd_i]);
`else
  assign resp_legal = 1'b1;
`endif

  assign resp_take = resp_valid_i && resp_legal;
  // A pop in the same cycle frees the slot the push needs, so a full buffer still accepts.
  assign resp_push = resp_take && (!resp_full || wb_hs);
  assign resp_err_set = (resp_valid_i && !resp_legal) || (resp_take && resp_full && !wb_hs);

  // ---------------------------------------------------------------------------------------------
  // Flush: mark every occupied entry except a head that is leaving this cycle
  // ---------------------------------------------------------------------------------------------
  logic [CMD_DEPTH-1:0] cmd_discard;

  always_comb begin
    cmd_discard = '0;
    for (int unsigned i = 0; i < CMD_DEPTH; i++) begin
      logic [CmdAw-1:0] offset;
      offset = CmdAw'(i) - cmd_head_idx;
      if (({1'b0, offset} < cmd_count) && !(cmd_hs && (offset == '0))) begin
        cmd_discard[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    cmd_rptr_d = cmd_rptr_q;
    if (cmd_hs) begin
      cmd_rptr_d = cmd_rptr_q + CmdPtrOne;
    end
    cmd_wptr_d = cmd_wptr_q;
    if (flush_i) begin
      cmd_wptr_d = cmd_rptr_d;
    end else if (issue_hs) begin
      cmd_wptr_d = cmd_wptr_q + CmdPtrOne;
    end
  end

  always_comb begin
    resp_rptr_d = resp_rptr_q;
    resp_wptr_d = resp_wptr_q;
    if (wb_hs) begin
      resp_rptr_d = resp_rptr_q + RespPtrOne;
    end
    if (resp_push) begin
      resp_wptr_d = resp_wptr_q + RespPtrOne;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (cmd_hs && cmd_xd_o) begin
      inflight_d = inflight_d + CntOne;
    end
    if (resp_take && (inflight_q != '0)) begin
      inflight_d = inflight_d - CntOne;
    end
  end

  // Clear before set: the hazard check keeps an issue from targeting a register that is
  // being written back, so ordering only matters for consistency.
  always_comb begin
    rd_pending_d = rd_pending_q;
    if (wb_hs) begin
      rd_pending_d[wb_rd_o] = 1'b0;
    end
    if (flush_i) begin
      for (int unsigned i = 0; i < CMD_DEPTH; i++) begin
        if (cmd_discard[i] && cmd_xd_q[i]) begin
          rd_pending_d[cmd_rd_q[i]] = 1'b0;
        end
      end
    end
    if (issue_hs && issue_xd_i) begin
      rd_pending_d[issue_rd_i] = 1'b1;
    end
    rd_pending_d[0] = 1'b0;
  end

  assign resp_err_d = resp_err_q || resp_err_set;

  // ---------------------------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_wptr_q   <= '0;
      cmd_rptr_q   <= '0;
      resp_wptr_q  <= '0;
      resp_rptr_q  <= '0;
      inflight_q   <= '0;
      rd_pending_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      cmd_wptr_q   <= cmd_wptr_d;
      cmd_rptr_q   <= cmd_rptr_d;
      resp_wptr_q  <= resp_wptr_d;
      resp_rptr_q  <= resp_rptr_d;
      inflight_q   <= inflight_d;
      rd_pending_q <= rd_pending_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage is reset too so every output field reads 0 while in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < CMD_DEPTH; i++) begin
        cmd_funct7_q[i] <= '0;
        cmd_rs1_q[i]    <= '0;
        cmd_rs2_q[i]    <= '0;
        cmd_rd_q[i]     <= '0;
        cmd_xd_q[i]     <= 1'b0;
      end
    end else if (issue_hs) begin
      cmd_funct7_q[cmd_tail_idx] <= issue_funct7_i;
      cmd_rs1_q[cmd_tail_idx]    <= issue_rs1_i;
      cmd_rs2_q[cmd_tail_idx]    <= issue_rs2_i;
      cmd_rd_q[cmd_tail_idx]     <= issue_rd_i;
      cmd_xd_q[cmd_tail_idx]     <= issue_xd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < RESP_DEPTH; i++) begin
        resp_data_q[i] <= '0;
        resp_rd_q[i]   <= '0;
      end
    end else if (resp_push) begin
      resp_data_q[resp_tail_idx] <= resp_data_i;
      resp_rd_q[resp_tail_idx]   <= resp_rd_i;
    end
  end

endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// Self-checking bench for rocc_cmd_issuer: directed scenarios followed by random traffic, all
// compared every cycle against a queue-based reference model.
module tb_rocc_cmd_issuer;

  localparam int XL = 64;
  localparam int CD = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          issue_valid, issue_ready, issue_xd;
  logic [6:0]    issue_f7;
  logic [XL-1:0] issue_rs1, issue_rs2;
  logic [4:0]    issue_rd;
  logic          cmd_valid, cmd_ready, cmd_xd;
  logic [6:0]    cmd_f7;
  logic [XL-1:0] cmd_rs1, cmd_rs2;
  logic [4:0]    cmd_rd;
  logic          resp_valid;
  logic [XL-1:0] resp_data;
  logic [4:0]    resp_rd;
  logic          wb_valid, wb_ready;
  logic [XL-1:0] wb_data;
  logic [4:0]    wb_rd;
  logic [31:0]   rd_pending;
  logic          busy, resp_err;

  always #5 clk = ~clk;

  rocc_cmd_issuer #(.XLEN(XL), .CMD_DEPTH(CD), .RESP_DEPTH(RD)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_funct7_i(issue_f7), .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
    .issue_rd_i(issue_rd), .issue_xd_i(issue_xd),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_funct7_o(cmd_f7),
    .cmd_rs1_o(cmd_rs1), .cmd_rs2_o(cmd_rs2), .cmd_rd_o(cmd_rd), .cmd_xd_o(cmd_xd),
    .resp_valid_i(resp_valid), .resp_data_i(resp_data), .resp_rd_i(resp_rd),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_data_o(wb_data), .wb_rd_o(wb_rd),
    .rd_pending_o(rd_pending), .busy_o(busy), .resp_err_o(resp_err)
  );

  // Reference model
  typedef struct packed {
    logic [6:0]    f7;
    logic [XL-1:0] rs1;
    logic [XL-1:0] rs2;
    logic [4:0]    rd;
    logic          xd;
  } cmd_t;
  typedef struct packed {
    logic [XL-1:0] data;
    logic [4:0]    rd;
  } resp_t;

  cmd_t        cq[$];
  resp_t       rq[$];
  resp_t       acc_q[$];  // accelerator: responses owed for sent xd commands
  int          infl;
  logic [31:0] pend;
  logic        err;

  int total = 0;
  int bad   = 0;
  int n_sent = 0;
  bit last_issue_hs;
  bit auto_resp;
  int resp_pct;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cq.delete(); rq.delete(); acc_q.delete();
    infl = 0; pend = '0; err = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".issue_ready"}, 64'(issue_ready), 64'd0);
    chk({tag, ".cmd_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, ".cmd_fields"}, 64'(cmd_f7) | cmd_rs1 | cmd_rs2 | 64'(cmd_rd) | 64'(cmd_xd), 64'd0);
    chk({tag, ".wb_valid"}, 64'(wb_valid), 64'd0);
    chk({tag, ".wb_fields"}, wb_data | 64'(wb_rd), 64'd0);
    chk({tag, ".rd_pending"}, 64'(rd_pending), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".resp_err"}, 64'(resp_err), 64'd0);
  endtask

  // One clock cycle: inputs already set at the falling edge; check, then advance the model.
  task automatic cyc();
    bit exp_ir, exp_cv, exp_wv, cmd_hs, issue_hs, wb_hs, legal, take, full_before;
    int nin;
    resp_t r;
    if (auto_resp) begin
      if (acc_q.size() > 0 && $urandom_range(99) < resp_pct) begin
        r = acc_q.pop_front();
        resp_valid = 1'b1; resp_data = r.data; resp_rd = r.rd;
      end else begin
        resp_valid = 1'b0;
      end
    end
    #1;
    exp_cv = cq.size() > 0 && (!cq[0].xd || (infl + rq.size()) < RD);
    exp_ir = cq.size() < CD && !flush && !(issue_xd && pend[issue_rd]);
    exp_wv = rq.size() > 0;
    chk("issue_ready", 64'(issue_ready), 64'(exp_ir));
    chk("cmd_valid", 64'(cmd_valid), 64'(exp_cv));
    if (exp_cv) begin
      chk("cmd_f7", 64'(cmd_f7), 64'(cq[0].f7));
      chk("cmd_rs1", cmd_rs1, cq[0].rs1);
      chk("cmd_rs2", cmd_rs2, cq[0].rs2);
      chk("cmd_rd", 64'(cmd_rd), 64'(cq[0].rd));
      chk("cmd_xd", 64'(cmd_xd), 64'(cq[0].xd));
    end
    chk("wb_valid", 64'(wb_valid), 64'(exp_wv));
    if (exp_wv) begin
      chk("wb_data", wb_data, rq[0].data);
      chk("wb_rd", 64'(wb_rd), 64'(rq[0].rd));
    end
    chk("rd_pending", 64'(rd_pending), 64'(pend));
    chk("busy", 64'(busy), 64'(cq.size() != 0 || infl != 0 || rq.size() != 0));
    chk("resp_err", 64'(resp_err), 64'(err));

    cmd_hs   = exp_cv && cmd_ready;
    issue_hs = issue_valid && exp_ir;
    wb_hs    = exp_wv && wb_ready;
    last_issue_hs = issue_hs;
    legal = 1'b1;
`ifdef ROCC_RESP_CHECK_EN
    legal = (infl != 0) && (resp_rd == 5'd0 || pend[resp_rd]);
`endif
    take = resp_valid && legal;
    full_before = rq.size() >= RD;
    @(posedge clk);
    if (wb_hs) pend[rq[0].rd] = 1'b0;
    if (flush) begin
      for (int i = (cmd_hs ? 1 : 0); i < cq.size(); i++) if (cq[i].xd) pend[cq[i].rd] = 1'b0;
    end
    if (issue_hs && issue_xd) pend[issue_rd] = 1'b1;
    pend[0] = 1'b0;
    nin = infl;
    if (cmd_hs) begin
      n_sent++;
      if (cq[0].xd) begin
        nin++;
        acc_q.push_back('{data: cq[0].rs1 + cq[0].rs2, rd: cq[0].rd});
      end
    end
    if (take && infl > 0) nin--;
    infl = nin;
    if (resp_valid && !legal) err = 1'b1;
    if (take && full_before && !wb_hs) err = 1'b1;
    if (wb_hs) void'(rq.pop_front());
    if (take && (!full_before || wb_hs)) rq.push_back('{data: resp_data, rd: resp_rd});
    if (cmd_hs) void'(cq.pop_front());
    if (flush) cq.delete();
    if (issue_hs) cq.push_back('{f7: issue_f7, rs1: issue_rs1, rs2: issue_rs2,
                                 rd: issue_rd, xd: issue_xd});
    @(negedge clk);
  endtask

  task automatic issue_one(input logic [6:0] f7, input logic [XL-1:0] a, input logic [XL-1:0] b,
                           input logic [4:0] rd, input logic xd);
    bit ok = 1'b0;
    issue_valid = 1'b1; issue_f7 = f7; issue_rs1 = a; issue_rs2 = b; issue_rd = rd;
    issue_xd = xd;
    for (int i = 0; i < 60 && !ok; i++) begin
      cyc();
      ok = last_issue_hs;
    end
    issue_valid = 1'b0;
    chk("issue_accept", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    bit idle = 1'b0;
    issue_valid = 1'b0; flush = 1'b0; cmd_ready = 1'b1; wb_ready = 1'b1;
    auto_resp = 1'b1; resp_pct = 100;
    for (int i = 0; i < 100 && !idle; i++) begin
      cyc();
      idle = cq.size() == 0 && infl == 0 && rq.size() == 0 && acc_q.size() == 0;
    end
    chk("drain_idle", 64'(idle), 64'd1);
  endtask

  initial begin
    int sent0;
    rst_n = 1'b0; flush = 1'b0; cmd_ready = 1'b0; wb_ready = 1'b0;
    issue_valid = 1'b1; issue_f7 = 7'h11; issue_rs1 = '1; issue_rs2 = '1; issue_rd = 5'd3;
    issue_xd = 1'b1; resp_valid = 1'b0; resp_data = '0; resp_rd = '0;
    auto_resp = 1'b0; resp_pct = 0;
    model_reset();
    @(negedge clk); #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1; issue_valid = 1'b0;

    // Single xd command: data returned is rs1+rs2 = 0xC.
    cmd_ready = 1'b1; wb_ready = 1'b1; auto_resp = 1'b1; resp_pct = 100;
    issue_one(7'h01, 64'd5, 64'd7, 5'd3, 1'b1);
    chk("single_cmd_valid", 64'(cmd_valid), 64'd1);
    cyc();  // command handshake
    cyc();  // response arrives
    chk("single_wb_data", wb_data, 64'hC);
    chk("single_wb_rd", 64'(wb_rd), 64'd3);
    chk("single_pending3", 64'(rd_pending[3]), 64'd1);
    drain();

    // Credit stall: 4 of 5 xd commands go out while writeback is held.
    wb_ready = 1'b0;
    sent0 = n_sent;
    for (int i = 1; i <= 5; i++) issue_one(7'h02, 64'(i), 64'(i), 5'(i), 1'b1);
    for (int i = 0; i < 6; i++) cyc();
    chk("credit_sent4", 64'(n_sent - sent0), 64'd4);
    wb_ready = 1'b1; cyc(); wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("credit_sent5", 64'(n_sent - sent0), 64'd5);
    drain();

    // Hazard: second xd to rd 7 waits for the first writeback.
    wb_ready = 1'b0;
    issue_one(7'h03, 64'd1, 64'd2, 5'd7, 1'b1);
    issue_valid = 1'b1; issue_rd = 5'd7; issue_xd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hazard_blocked", 64'(issue_ready), 64'd0);
    end
    wb_ready = 1'b1;
    issue_one(7'h04, 64'd3, 64'd4, 5'd7, 1'b1);
    issue_one(7'h05, 64'd0, 64'd0, 5'd8, 1'b0);
    drain();

    // Flush with three queued xd commands.
    cmd_ready = 1'b0;
    issue_one(7'h06, 64'd1, 64'd1, 5'd2, 1'b1);
    issue_one(7'h06, 64'd1, 64'd1, 5'd4, 1'b1);
    issue_one(7'h06, 64'd1, 64'd1, 5'd6, 1'b1);
    flush = 1'b1; cyc(); flush = 1'b0;
    #1;
    chk("flush_pending", 64'(rd_pending), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    cyc();

    // Unsolicited responses, full-buffer push with same-cycle pop, then overflow.
    auto_resp = 1'b0; wb_ready = 1'b0; cmd_ready = 1'b1;
    resp_valid = 1'b1; resp_rd = 5'd9; resp_data = 64'h99; cyc(); resp_valid = 1'b0;
`ifdef ROCC_RESP_CHECK_EN
    #1;
    chk("unsol_err", 64'(resp_err), 64'd1);
    chk("unsol_wb_valid", 64'(wb_valid), 64'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      resp_valid = 1'b1; resp_rd = 5'd0; resp_data = 64'(i); cyc();
    end
    wb_ready = 1'b1; resp_data = 64'hAA; cyc();
    wb_ready = 1'b0; resp_data = 64'hBB; cyc();
    resp_valid = 1'b0; cyc();
    drain();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      issue_valid = ($urandom_range(99) < 60);
      issue_f7 = 7'($urandom); issue_rs1 = {$urandom, $urandom}; issue_rs2 = {$urandom, $urandom};
      issue_rd = 5'($urandom_range(7)); issue_xd = 1'($urandom_range(1));
      cmd_ready = ($urandom_range(99) < 70); wb_ready = ($urandom_range(99) < 60);
      flush = ($urandom_range(99) < 3); resp_pct = 40;
      cyc();
    end
    drain();

    // Reset with two commands queued and one in flight.
    auto_resp = 1'b0; resp_valid = 1'b0; cmd_ready = 1'b1;
    issue_one(7'h07, 64'd1, 64'd1, 5'd1, 1'b1);
    cyc();
    cmd_ready = 1'b0;
    issue_one(7'h07, 64'd1, 64'd1, 5'd2, 1'b1);
    issue_one(7'h07, 64'd1, 64'd1, 5'd3, 1'b1);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0; #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 150; n++) begin
      issue_valid = ($urandom_range(99) < 50);
      issue_f7 = 7'($urandom); issue_rs1 = {$urandom, $urandom}; issue_rs2 = {$urandom, $urandom};
      issue_rd = 5'($urandom_range(15)); issue_xd = 1'($urandom_range(1));
      cmd_ready = ($urandom_range(99) < 80); wb_ready = ($urandom_range(99) < 50);
      flush = 1'b0; auto_resp = 1'b1; resp_pct = 50;
      cyc();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rocc_cmd_issuer.md
# rocc_cmd_issuer

Core-side endpoint of the RoCC command/response interface. Accepts custom-opcode instructions from the issue stage, queues them, and drives the command channel toward the accelerator. Collects accelerator responses, which have no back-pressure, into a credit-protected buffer and returns them to the integer writeback path. Maintains a destination-register scoreboard so the pipeline can stall on RAW/WAW hazards against pending accelerator results.

## Interface
- `XLEN`, 64: operand and response data width.
- `CMD_DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `RESP_DEPTH`, 4: response buffer entries and response credits; power of 2, ≥2.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: drop queued, unsent commands.
- `issue_valid_i` in 1, `issue_ready_o` out 1: issue handshake.
- `issue_funct7_i` in 7, `issue_rs1_i` in XLEN, `issue_rs2_i` in XLEN, `issue_rd_i` in 5, `issue_xd_i` in 1: instruction fields; `xd`=1 means a response is expected.
- `cmd_valid_o` out 1, `cmd_ready_i` in 1: command handshake to the accelerator.
- `cmd_funct7_o` out 7, `cmd_rs1_o` out XLEN, `cmd_rs2_o` out XLEN, `cmd_rd_o` out 5, `cmd_xd_o` out 1: command fields.
- `resp_valid_i` in 1, `resp_data_i` in XLEN, `resp_rd_i` in 5: response channel; no ready signal, so a response is taken every cycle it is valid.
- `wb_valid_o` out 1, `wb_ready_i` in 1, `wb_data_o` out XLEN, `wb_rd_o` out 5: writeback handshake.
- `rd_pending_o` out 32: scoreboard bitmap; bit 0 is always 0.
- `busy_o` out 1: any command queued, in flight, or buffered.
- `resp_err_o` out 1: sticky error flag.

## Operation
- **Issue acceptance.** `issue_ready_o` = !cmd_full && !flush_i && !(issue_xd_i && rd_pending[issue_rd_i]).
  - On accept, push the entry into the command FIFO.
  - If xd and rd≠0, set `rd_pending[rd]`.
- **Command send.**
  - `cmd_valid_o` = FIFO non-empty && (!head.xd || credit_ok).
  - credit_ok = inflight + resp_count < RESP_DEPTH.
  - A handshake pops the head; an xd command increments `inflight`.
  - Command fields come directly from the FIFO head registers.
- **Response capture.** When `resp_valid_i`=1:
  - Push {data, rd} into the response buffer.
  - Decrement `inflight` (saturating at 0).
  - If the buffer is full, drop the response and set `resp_err_o`.
- **Writeback.**
  - `wb_valid_o` = response buffer non-empty.
  - A handshake pops the buffer and clears `rd_pending[wb_rd_o]`.
  - rd=0 responses are written back normally; the regfile ignores them.
- **Flush.**
  - All FIFO entries not handshaked in that cycle are discarded.
  - The `rd_pending` bits of discarded xd entries are cleared.
  - A head handshaking in the flush cycle is sent and counted as in flight.
  - In-flight commands and buffered responses are unaffected.
- `busy_o` = cmd non-empty || inflight≠0 || resp non-empty.
- `resp_err_o` clears only on reset.
- Counter widths: `inflight` and `resp_count` are $clog2(RESP_DEPTH)+1 bits. Pointers wrap modulo depth, with an extra wrap bit for full/empty detection.

## Timing
- **Reset values.** Every output is 0: valids, ready, `busy_o`, `resp_err_o`, `rd_pending_o`, and all data fields. FIFOs empty, `inflight`=0.
- `issue_ready_o` is 0 during reset, then follows its combinational equation.
- **Issue → cmd_valid_o:** 1 cycle minimum. There is no bypass, since the FIFO is registered.
- **resp_valid_i → wb_valid_o:** 1 cycle.
- **rd_pending_o:** a bit set at issue is visible the next cycle. A bit cleared at writeback is visible the next cycle.
- **Same-cycle issue with matching writeback.** An issue to rd X in the same cycle as the writeback of rd X is still blocked, because the pending bit is still set that cycle.
- **Full conditions.**
  - cmd FIFO full: issue stalls.
  - Credits exhausted: an xd head stalls while non-xd heads proceed. The FIFO is in order, so a stalled xd head blocks everything behind it.
- **Simultaneous events.** Response push and writeback pop in the same cycle keep the count unchanged. This works even when the buffer is full, so a response arriving while full with a pop in the same cycle is not dropped.
- **Mid-operation reset.** Asynchronous reset empties all state immediately. Responses already in flight from the accelerator are not tracked after reset.

## Configuration
- **`ROCC_RESP_CHECK_EN` defined:**
  - A response is dropped and sets `resp_err_o` if it arrives with `inflight`=0.
  - It is also dropped if resp_rd≠0 and `rd_pending[resp_rd]`=0.
  - Dropped responses do not decrement `inflight`.
- **`ROCC_RESP_CHECK_EN` undefined:** every response is pushed, and only buffer overflow sets `resp_err_o`.

## Test plan
- **Single xd command.** Issue funct7=0x01, rs1=5, rs2=7, rd=3, xd=1; accelerator accepts then responds 0xC rd=3.
  - cmd_valid_o 1 cycle after issue.
  - wb_data_o=0xC, wb_rd_o=3 one cycle after the response.
  - `rd_pending_o[3]` high from the issue+1 cycle through the writeback handshake cycle.
- **Credit stall.** RESP_DEPTH=4, `wb_ready_i`=0, accelerator accepts 5 xd commands to rd 1..5 and responds promptly.
  - Exactly 4 commands are sent; the 5th is held.
  - After one writeback handshake, the 5th is sent.
- **Hazard stall.** Issue xd rd=7, then another xd rd=7: `issue_ready_o`=0 until writeback of rd 7 completes. A following non-xd command also waits, since issue is in order.
- **Flush.** Queue 3 xd commands (rd 2, 4, 6) with `cmd_ready_i`=0, then pulse `flush_i`.
  - FIFO empties and `rd_pending_o`=0.
  - `busy_o`=0 the next cycle.
- **Unsolicited response.** With the macro defined, drive `resp_valid_i`=1 with rd=9 while idle.
  - `resp_err_o`=1.
  - `wb_valid_o` stays 0.
- **Reset mid-operation.** Assert `rst_ni`=0 with 2 commands queued and 1 in flight: all outputs are 0 immediately.
